lzy_serial_nibble_rx: RTL and testbench



---
 rtl/lzy_ser_pkg.sv | 17 +
 rtl/lzy_sipo_shift.sv | 25 ++
 rtl/lzy_serial_nibble_rx.sv | 108 ++++++++++
 tb/tb_lzy_serial_nibble_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lzy_ser_pkg.sv
// Shared types and constants for the lzy serial nibble receiver.
package lzy_ser_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int unsigned RX_DEF_WIDTH = 4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/lzy_sipo_shift.sv
// Serial-in parallel-out shift register; a new bit enters at index 0 and
// older bits move toward index WIDTH-1, so the first bit lands in o_q[WIDTH-1].
module lzy_sipo_shift #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [0:WIDTH-1] o_q
);

  logic [0:WIDTH-1] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= {i_sin, r_sr[0:WIDTH-2]};
    end
  end

  assign o_q = r_sr;

endmodule

// File: rtl/lzy_serial_nibble_rx.sv
// Framed serial receiver with valid/ack handoff and framing/overrun reporting.
// Define LZY_RX_PARITY_EN to add an even-parity bit and the Perr output.
module lzy_serial_nibble_rx
  import lzy_ser_pkg::*;
#(
  parameter int unsigned WIDTH = RX_DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             Ben,
  input  logic             Sin,
  input  logic             Ack,
  output logic [0:WIDTH-1] Q,
  output logic             Valid,
  output logic             Ferr,
  output logic             Ovr
`ifdef LZY_RX_PARITY_EN
  ,
  output logic             Perr
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic [0:WIDTH-1] w_sr;
  logic             w_shift;

  assign w_shift = (r_state == RX_DATA) && Ben;

  lzy_sipo_shift #(.WIDTH(WIDTH)) u_sipo (
    .i_clk   (Clk),
    .i_rst_n (MR),
    .i_shift (w_shift),
    .i_sin   (Sin),
    .o_q     (w_sr)
  );

`ifdef LZY_RX_PARITY_EN
  logic r_par_bad;
`endif

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      Q       <= '0;
      Valid   <= 1'b0;
      Ferr    <= 1'b0;
      Ovr     <= 1'b0;
`ifdef LZY_RX_PARITY_EN
      Perr      <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      Ferr <= 1'b0;
      Ovr  <= 1'b0;
`ifdef LZY_RX_PARITY_EN
      Perr <= 1'b0;
`endif
      // A good completion below overrides this clear, keeping Valid high.
      if (Valid && Ack) Valid <= 1'b0;

      if (Ben) begin
        unique case (r_state)
          RX_IDLE: begin
            if (Sin == LINE_START) r_state <= RX_DATA;
          end
          RX_DATA: begin
            if (r_cnt == LAST_BIT) begin
              r_cnt <= '0;
`ifdef LZY_RX_PARITY_EN
              r_state <= RX_PARITY;
`else
              r_state <= RX_STOP;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`ifdef LZY_RX_PARITY_EN
          RX_PARITY: begin
            r_par_bad <= Sin ^ (^w_sr);
            r_state   <= RX_STOP;
          end
`endif
          RX_STOP: begin
            r_state <= RX_IDLE;
            if (Sin == LINE_STOP) begin
              Q     <= w_sr;
              Valid <= 1'b1;
              Ovr   <= Valid & ~Ack;
`ifdef LZY_RX_PARITY_EN
              Perr  <= r_par_bad;
`endif
            end else begin
              Ferr <= 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lzy_serial_nibble_rx.sv
// Bench for lzy_serial_nibble_rx: frame-level queue model checked every cycle,
// plus literal checks on bit placement. Honours LZY_RX_PARITY_EN when defined.
module tb_lzy_serial_nibble_rx;

  localparam int W = 4;
`ifdef LZY_RX_PARITY_EN
  localparam int FRAME = W + 3;
`else
  localparam int FRAME = W + 2;
`endif

  logic         Clk = 1'b0;
  logic         MR  = 1'b1;
  logic         Ben = 1'b0;
  logic         Sin = 1'b1;
  logic         Ack = 1'b0;
  logic [0:W-1] Q;
  logic         Valid, Ferr, Ovr;
`ifdef LZY_RX_PARITY_EN
  logic         Perr;
`endif

  lzy_serial_nibble_rx #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .MR    (MR),
    .Ben   (Ben),
    .Sin   (Sin),
    .Ack   (Ack),
    .Q     (Q),
    .Valid (Valid),
    .Ferr  (Ferr),
    .Ovr   (Ovr)
`ifdef LZY_RX_PARITY_EN
    ,
    .Perr  (Perr)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect the Ben samples of a frame, judge it once it is complete.
  bit           fq[$];
  logic [0:W-1] m_q = '0;
  logic [0:W-1] m_w;
  logic         m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  logic         m_del, m_par;

  always @(posedge Clk or negedge MR) begin
    if (!MR) begin
      fq.delete();
      m_q = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_del = 1'b0;
      if (Ben && (fq.size() != 0 || Sin == 1'b0)) fq.push_back(Sin);
      if (fq.size() == FRAME) begin
        m_par = 1'b0;
        for (int k = 0; k < W; k++) begin
          m_w[W-1-k] = fq[1+k];
          m_par ^= fq[1+k];
        end
        if (fq[FRAME-1]) begin
          m_ovr   = m_valid && !Ack;
          m_q     = m_w;
          m_valid = 1'b1;
          m_del   = 1'b1;
`ifdef LZY_RX_PARITY_EN
          m_perr  = (m_par != fq[W+1]);
`endif
        end else begin
          m_ferr = 1'b1;
        end
        fq.delete();
      end
      if (!m_del && Ack) m_valid = 1'b0;
    end
  end

  logic checking = 1'b0;

  always @(negedge Clk) begin
    if (checking) begin
      check("Q", Q, m_q);
      check("Valid", Valid, m_valid);
      check("Ferr", Ferr, m_ferr);
      check("Ovr", Ovr, m_ovr);
`ifdef LZY_RX_PARITY_EN
      check("Perr", Perr, m_perr);
`endif
    end
  end

  task automatic send_bit(input logic b, input int gap, input logic ack);
    @(negedge Clk);
    Ben = 1'b1; Sin = b; Ack = ack;
    @(negedge Clk);
    Ben = 1'b0; Ack = 1'b0;
    for (int i = 0; i < gap; i++) begin
      Sin = ~b;
      @(negedge Clk);
    end
  endtask

  // d is given in line order: d[W-1] is sent first.
  task automatic frame(input logic [W-1:0] d, input logic stop, input logic par,
                       input int gap, input logic ack_stop);
    send_bit(1'b0, gap, 1'b0);
    for (int i = W - 1; i >= 0; i--) send_bit(d[i], gap, 1'b0);
`ifdef LZY_RX_PARITY_EN
    send_bit(par, gap, 1'b0);
`else
    if (par) Sin = 1'b1;
`endif
    send_bit(stop, 0, ack_stop);
    Sin = 1'b1;
  endtask

  task automatic ack_word();
    @(negedge Clk);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  initial begin
    #2 MR = 1'b0;
    #1;
    check("rst_Q", Q, 0);
    check("rst_Valid", Valid, 0);
    check("rst_Ferr", Ferr, 0);
    check("rst_Ovr", Ovr, 0);
    checking = 1'b1;
    #9 MR = 1'b1;

    // Basic frame; literal checks read Q by index, Q[3] holds the first bit.
    frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
    check("lit_q_1011", {Q[3], Q[2], Q[1], Q[0]}, 4'b1011);
    check("lit_valid", Valid, 1);
    check("lit_no_ferr", Ferr, 0);
    ack_word();
    check("lit_ack_clears", Valid, 0);
    check("lit_q_held", {Q[3], Q[2], Q[1], Q[0]}, 4'b1011);

    // Bad stop bit, then a good frame.
    frame(4'b0110, 1'b0, 1'b0, 0, 1'b0);
    check("lit_ferr", Ferr, 1);
    check("lit_ferr_valid", Valid, 0);
    check("lit_ferr_q", {Q[3], Q[2], Q[1], Q[0]}, 4'b1011);
    frame(4'b0110, 1'b1, 1'b0, 0, 1'b0);
    check("lit_q_0110", {Q[3], Q[2], Q[1], Q[0]}, 4'b0110);
    ack_word();

    // Overrun, then completion with simultaneous Ack.
    frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
    frame(4'b0110, 1'b1, 1'b0, 0, 1'b0);
    check("lit_ovr", Ovr, 1);
    check("lit_ovr_q", {Q[3], Q[2], Q[1], Q[0]}, 4'b0110);
    frame(4'b1011, 1'b1, 1'b1, 0, 1'b1);
    check("lit_ack_no_ovr", Ovr, 0);
    check("lit_ack_valid", Valid, 1);
    ack_word();

    // Sparse Ben with Sin wiggling between strobes.
    frame(4'b1011, 1'b1, 1'b1, 1, 1'b0);
    check("lit_sparse_q", {Q[3], Q[2], Q[1], Q[0]}, 4'b1011);
    check("lit_sparse_valid", Valid, 1);

    // Reset mid-frame after two data bits.
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    #2 MR = 1'b0;
    #1;
    check("lit_mr_valid", Valid, 0);
    check("lit_mr_q", Q, 0);
    @(negedge Clk);
    #2 MR = 1'b1;
    frame(4'b1100, 1'b1, 1'b0, 0, 1'b0);
    check("lit_q_1100", {Q[3], Q[2], Q[1], Q[0]}, 4'b1100);
    check("lit_1100_valid", Valid, 1);
    ack_word();

    // Back-to-back frames at one strobe per clock.
    @(negedge Clk);
    Ben = 1'b1;
    foreach (fq[i]) Sin = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      Sin = (i % FRAME == 0) ? 1'b0 : ((i % FRAME == FRAME - 1) ? 1'b1 : logic'($urandom_range(0, 1)));
      @(negedge Clk);
    end
    Ben = 1'b0; Sin = 1'b1;
    check("lit_b2b_valid", Valid, 1);
    ack_word();

`ifdef LZY_RX_PARITY_EN
    frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
    check("lit_par_ok", Perr, 0);
    check("lit_par_ok_q", {Q[3], Q[2], Q[1], Q[0]}, 4'b1011);
    ack_word();
    frame(4'b1011, 1'b1, 1'b0, 0, 1'b0);
    check("lit_par_bad", Perr, 1);
    check("lit_par_bad_valid", Valid, 1);
    check("lit_par_bad_q", {Q[3], Q[2], Q[1], Q[0]}, 4'b1011);
    @(negedge Clk);
    check("lit_par_pulse_end", Perr, 0);
`endif

    repeat (4) @(negedge Clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
